// File: rtl/gc_pkg.sv
// rtl/gc_pkg.sv - states, header checks and report layout for the GameCube poll scheduler
package gc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_COMMIT,
    ST_WAIT
  } gc_state_e;

  // Header: bits [63:61] must be 000 and bit 55 must be 1
  localparam int HDR_ZERO_MSB = 63;
  localparam int HDR_ZERO_LSB = 61;
  localparam int HDR_ONE_BIT  = 55;

  localparam int BIT_START = 60;
  localparam int BIT_Y     = 59;
  localparam int BIT_X     = 58;
  localparam int BIT_B     = 57;
  localparam int BIT_A     = 56;
  localparam int BIT_L     = 54;
  localparam int BIT_R     = 53;
  localparam int BIT_Z     = 52;
  localparam int BIT_UP    = 51;
  localparam int BIT_DOWN  = 50;
  localparam int BIT_RIGHT = 49;
  localparam int BIT_LEFT  = 48;

  localparam int NUM_BUTTONS = 12;
  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_X     = 2;
  localparam int BTN_Y     = 3;
  localparam int BTN_START = 4;
  localparam int BTN_L     = 5;
  localparam int BTN_R     = 6;
  localparam int BTN_Z     = 7;
  localparam int BTN_UP    = 8;
  localparam int BTN_DOWN  = 9;
  localparam int BTN_RIGHT = 10;
  localparam int BTN_LEFT  = 11;

  function automatic logic header_ok(input logic [63:0] r);
    return (r[HDR_ZERO_MSB:HDR_ZERO_LSB] == 3'b000) && r[HDR_ONE_BIT];
  endfunction

  function automatic logic [NUM_BUTTONS-1:0] report_buttons(input logic [63:0] r);
    logic [NUM_BUTTONS-1:0] b;
    b = '0;
    b[BTN_A]     = r[BIT_A];
    b[BTN_B]     = r[BIT_B];
    b[BTN_X]     = r[BIT_X];
    b[BTN_Y]     = r[BIT_Y];
    b[BTN_START] = r[BIT_START];
    b[BTN_L]     = r[BIT_L];
    b[BTN_R]     = r[BIT_R];
    b[BTN_Z]     = r[BIT_Z];
    b[BTN_UP]    = r[BIT_UP];
    b[BTN_DOWN]  = r[BIT_DOWN];
    b[BTN_RIGHT] = r[BIT_RIGHT];
    b[BTN_LEFT]  = r[BIT_LEFT];
    return b;
  endfunction

endpackage

// File: rtl/gc_cycle_timer.sv
// rtl/gc_cycle_timer.sv - loadable up-counter that saturates at TERMINAL and flags it
module gc_cycle_timer #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == WIDTH'(TERMINAL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gc_poll_scheduler.sv
// rtl/gc_poll_scheduler.sv - periodic poll sequencer with timeout, report latch and button edges
module gc_poll_scheduler #(
  parameter int POLL_PERIOD = 1_666_667,
  parameter int TIMEOUT     = 50_000,
  parameter int MAX_FAIL    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        poll_start,
  input  logic        rx_done,
  input  logic        rx_error,
  input  logic [63:0] rx_data,
  output logic [63:0] report,
  output logic        report_valid,
  output logic [11:0] buttons_pressed,
  output logic        connected
);
  import gc_pkg::*;

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  gc_state_e        state;
  logic             period_tc;
  logic             timeout_tc;
  logic             timers_load;
  logic [11:0]      prev_buttons;
  logic [11:0]      new_buttons;
  logic [FW-1:0]    fail_cnt;
  logic [FW-1:0]    fail_next;
  logic             rx_good;
  logic             rx_fail;

  // Both timers read 1 in the cycle after poll_start, so count k means k cycles since the pulse
  assign timers_load = (state == ST_REQ);

  gc_cycle_timer #(.WIDTH(PW), .TERMINAL(POLL_PERIOD - 1)) u_period (
    .clk      (clk),
    .reset    (reset),
    .load     (timers_load),
    .load_val (PW'(1)),
    .tc       (period_tc)
  );

  gc_cycle_timer #(.WIDTH(TW), .TERMINAL(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (timers_load),
    .load_val (TW'(1)),
    .tc       (timeout_tc)
  );

  assign new_buttons = report_buttons(rx_data);
  // A response in the timeout cycle wins; a simultaneous rx_error still makes it a failure
  assign rx_good   = rx_done && !rx_error && header_ok(rx_data);
  assign rx_fail   = rx_error || (rx_done && !header_ok(rx_data)) || (!rx_done && timeout_tc);
  assign fail_next = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      poll_start      <= 1'b0;
      report          <= '0;
      report_valid    <= 1'b0;
      buttons_pressed <= '0;
      connected       <= 1'b0;
      prev_buttons    <= '0;
      fail_cnt        <= '0;
    end else begin
      poll_start      <= 1'b0;
      report_valid    <= 1'b0;
      buttons_pressed <= '0;
      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_REQ;
            poll_start <= 1'b1;
          end
          ST_REQ: state <= ST_RESP;
          ST_RESP: begin
            if (rx_good) begin
              state           <= ST_COMMIT;
              report          <= rx_data;
              report_valid    <= 1'b1;
              buttons_pressed <= new_buttons & ~prev_buttons;
              prev_buttons    <= new_buttons;
              fail_cnt        <= '0;
              connected       <= 1'b1;
            end else if (rx_fail) begin
              state    <= ST_WAIT;
              fail_cnt <= fail_next;
              if (fail_next == FW'(MAX_FAIL)) begin
                connected    <= 1'b0;
                prev_buttons <= '0;
              end
            end
          end
          ST_COMMIT: state <= ST_WAIT;
          ST_WAIT: begin
            if (period_tc) begin
              state      <= ST_REQ;
              poll_start <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// tb/tb_gc_poll_scheduler.sv - directed self-checking bench for gc_poll_scheduler
module tb_gc_poll_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rx_done;
  logic        rx_error;
  logic [63:0] rx_data;
  logic        poll_start;
  logic [63:0] report;
  logic        report_valid;
  logic [11:0] buttons_pressed;
  logic        connected;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] D_A   = 64'h0180_8080_8080_0000;
  localparam logic [63:0] D_AB  = 64'h0380_8080_8080_0000;
  localparam logic [63:0] D_AX  = 64'h0580_8080_8080_0000;
  localparam logic [63:0] D_B   = 64'h0280_8080_8080_0000;
  localparam logic [63:0] D_BAD = 64'h8080_8080_8080_0000;

  gc_poll_scheduler #(.POLL_PERIOD(100), .TIMEOUT(20), .MAX_FAIL(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .poll_start      (poll_start),
    .rx_done         (rx_done),
    .rx_error        (rx_error),
    .rx_data         (rx_data),
    .report          (report),
    .report_valid    (report_valid),
    .buttons_pressed (buttons_pressed),
    .connected       (connected)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_poll(input int limit);
    int found;
    found = 0;
    for (int i = 0; i < limit && found == 0; i++) begin
      @(negedge clk);
      if (poll_start === 1'b1) found = 1;
    end
    if (found == 0) begin
      total++; bad++;
      $display("FAIL wait_poll: no poll_start within %0d cycles", limit);
    end
  endtask

  task automatic pulse_rx(input logic [63:0] d, input logic err);
    rx_done  = 1'b1;
    rx_error = err;
    rx_data  = d;
    step(1);
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; rx_done = 1'b0; rx_error = 1'b0; rx_data = '0;
    step(2);
    total++;
    if ({poll_start, report_valid, connected, buttons_pressed, report} !== 79'd0) begin
      bad++;
      $display("FAIL reset_state: outputs=%h expected 0",
               {poll_start, report_valid, connected, buttons_pressed, report});
    end
    reset = 1'b0;
  endtask

  task automatic test_periodic;
    int gap;
    int saw_conn;
    saw_conn = 0;
    enable = 1'b1;
    step(1);
    total++;
    if (poll_start !== 1'b1) begin
      bad++; $display("FAIL first_poll: poll_start=%b expected 1", poll_start);
    end
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      do begin
        step(1);
        gap++;
        if (connected !== 1'b0) saw_conn = 1;
      end while (poll_start !== 1'b1 && gap < 150);
      total++;
      if (gap !== 100) begin
        bad++; $display("FAIL poll_gap%0d: gap=%0d expected 100", k, gap);
      end
    end
    total++;
    if (saw_conn !== 0) begin
      bad++; $display("FAIL periodic_connected: connected rose, expected 0");
    end
  endtask

  task automatic test_first_report;
    step(5);
    pulse_rx(D_A, 1'b0);
    total++;
    if (report !== D_A || report_valid !== 1'b1) begin
      bad++; $display("FAIL first_report: report=%h valid=%b expected %h 1", report, report_valid, D_A);
    end
    total++;
    if (buttons_pressed !== 12'h001 || connected !== 1'b1) begin
      bad++; $display("FAIL first_buttons: pressed=%h conn=%b expected 001 1", buttons_pressed, connected);
    end
    step(1);
    total++;
    if (report_valid !== 1'b0 || buttons_pressed !== 12'h000) begin
      bad++; $display("FAIL valid_pulse: valid=%b pressed=%h expected 0 000", report_valid, buttons_pressed);
    end
  endtask

  task automatic test_repeat;
    wait_poll(150);
    step(3);
    pulse_rx(D_A, 1'b0);
    total++;
    if (report_valid !== 1'b1 || buttons_pressed !== 12'h000) begin
      bad++; $display("FAIL repeat_held: valid=%b pressed=%h expected 1 000", report_valid, buttons_pressed);
    end
    wait_poll(150);
    step(3);
    pulse_rx(D_AB, 1'b0);
    total++;
    if (report !== D_AB || buttons_pressed !== 12'h002) begin
      bad++; $display("FAIL add_b: report=%h pressed=%h expected %h 002", report, buttons_pressed, D_AB);
    end
  endtask

  task automatic test_timeouts;
    logic exp_conn;
    for (int i = 0; i < 3; i++) begin
      wait_poll(150);
      step(20);
      total++;
      if (connected !== 1'b1) begin
        bad++; $display("FAIL timeout%0d_pre: connected=%b expected 1", i, connected);
      end
      step(1);
      exp_conn = (i < 2);
      total++;
      if (connected !== exp_conn) begin
        bad++; $display("FAIL timeout%0d_post: connected=%b expected %b", i, connected, exp_conn);
      end
    end
    total++;
    if (report !== D_AB) begin
      bad++; $display("FAIL timeout_report_held: report=%h expected %h", report, D_AB);
    end
    wait_poll(150);
    step(4);
    pulse_rx(D_A, 1'b0);
    total++;
    if (report_valid !== 1'b1 || buttons_pressed !== 12'h001 || connected !== 1'b1) begin
      bad++; $display("FAIL reconnect: valid=%b pressed=%h conn=%b expected 1 001 1",
                      report_valid, buttons_pressed, connected);
    end
  endtask

  task automatic test_timeout_boundary;
    wait_poll(150);
    step(20);
    pulse_rx(D_AX, 1'b0);
    total++;
    if (report_valid !== 1'b1 || report !== D_AX || buttons_pressed !== 12'h004) begin
      bad++; $display("FAIL response_wins: valid=%b report=%h pressed=%h expected 1 %h 004",
                      report_valid, report, buttons_pressed, D_AX);
    end
    wait_poll(150);
    step(21);
    pulse_rx(D_B, 1'b0);
    total++;
    if (report_valid !== 1'b0 || report !== D_AX) begin
      bad++; $display("FAIL late_ignored: valid=%b report=%h expected 0 %h", report_valid, report, D_AX);
    end
  endtask

  task automatic test_bad_header;
    wait_poll(150);
    step(2);
    pulse_rx(D_AX, 1'b0);
    total++;
    if (report_valid !== 1'b1 || buttons_pressed !== 12'h000) begin
      bad++; $display("FAIL clear_fails: valid=%b pressed=%h expected 1 000", report_valid, buttons_pressed);
    end
    wait_poll(150);
    step(3);
    pulse_rx(D_BAD, 1'b0);
    total++;
    if (report_valid !== 1'b0 || report !== D_AX || connected !== 1'b1) begin
      bad++; $display("FAIL bad_header: valid=%b report=%h conn=%b expected 0 %h 1",
                      report_valid, report, connected, D_AX);
    end
    wait_poll(150);
    step(3);
    pulse_rx(D_A, 1'b1);
    total++;
    if (report_valid !== 1'b0 || report !== D_AX) begin
      bad++; $display("FAIL done_with_error: valid=%b report=%h expected 0 %h", report_valid, report, D_AX);
    end
    wait_poll(150);
    step(3);
    enable = 1'b0;
    step(1);
    pulse_rx(D_A, 1'b0);
    total++;
    if (report_valid !== 1'b0 || report !== D_AX || poll_start !== 1'b0) begin
      bad++; $display("FAIL disabled_drop: valid=%b report=%h poll=%b expected 0 %h 0",
                      report_valid, report, poll_start, D_AX);
    end
    enable = 1'b1;
    step(1);
    total++;
    if (poll_start !== 1'b1) begin
      bad++; $display("FAIL reenable_poll: poll_start=%b expected 1", poll_start);
    end
    step(20);
    total++;
    if (connected !== 1'b1) begin
      bad++; $display("FAIL third_fail_pre: connected=%b expected 1", connected);
    end
    step(1);
    total++;
    if (connected !== 1'b0) begin
      bad++; $display("FAIL third_fail_drop: connected=%b expected 0", connected);
    end
  endtask

  task automatic test_reset_mid;
    wait_poll(150);
    step(2);
    pulse_rx(D_A, 1'b0);
    total++;
    if (connected !== 1'b1 || buttons_pressed !== 12'h001) begin
      bad++; $display("FAIL pre_reset_report: conn=%b pressed=%h expected 1 001", connected, buttons_pressed);
    end
    wait_poll(150);
    step(3);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({poll_start, report_valid, connected, buttons_pressed, report} !== 79'd0) begin
      bad++; $display("FAIL async_reset: outputs=%h expected 0",
                      {poll_start, report_valid, connected, buttons_pressed, report});
    end
    step(2);
    reset = 1'b0;
    step(1);
    total++;
    if (poll_start !== 1'b1 || report !== 64'd0) begin
      bad++; $display("FAIL post_reset_poll: poll=%b report=%h expected 1 0", poll_start, report);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_first_report();
    test_repeat();
    test_timeouts();
    test_timeout_boundary();
    test_bad_header();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
